// File: rtl/lif_array.sv
// Time-multiplexed bank of N leaky integrate-and-fire neurons; 1-cycle registered result, in_ready = !out_valid | out_ready.
// Optional per-neuron adaptive threshold enabled by defining LIF_ADAPT_THR_EN.
module lif_array #(
   parameter int W       = 8,
   parameter int N       = 4,
   parameter int IDX_W   = 2,
   parameter int REFRACT = 2,
   parameter int THR_INC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic [W-1:0]     in_current,
   input  logic [2:0]       beta,
   input  logic [W-1:0]     thr_base,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_spike,
   output logic [W-1:0]     out_state
);

   localparam int R_W = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);
   localparam logic [W-1:0] VMAX = '1;

   logic [W-1:0]   v [N];
   logic [R_W-1:0] r [N];

   logic           accept;
   logic           hit;
   logic [W-1:0]   cur_v;
   logic [R_W-1:0] cur_r;
   logic [W+1:0]   sum;
   logic [W-1:0]   u;
   logic [W-1:0]   thr;
   logic           refr;
   logic           fire;
   logic [W-1:0]   new_v;

`ifdef LIF_ADAPT_THR_EN
   logic [W-1:0] thr_off [N];
   logic [W-1:0] cur_off;
   logic [W:0]   thr_sum;
   logic [W:0]   inc_sum;
`endif

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Out-of-range indices match nothing, so they read as an idle neuron and write nowhere.
   always_comb begin
      hit   = 1'b0;
      cur_v = '0;
      cur_r = '0;
`ifdef LIF_ADAPT_THR_EN
      cur_off = '0;
`endif
      for (int i = 0; i < N; i++) begin
         if (in_idx == IDX_W'(i)) begin
            hit   = 1'b1;
            cur_v = v[i];
            cur_r = r[i];
`ifdef LIF_ADAPT_THR_EN
            cur_off = thr_off[i];
`endif
         end
      end
   end

   always_comb begin
      sum = (W+2)'(beta[0] ? (cur_v >> 1) : '0)
          + (W+2)'(beta[1] ? (cur_v >> 2) : '0)
          + (W+2)'(beta[2] ? (cur_v >> 3) : '0)
          + (W+2)'(in_current);
      u = (sum > (W+2)'(VMAX)) ? VMAX : sum[W-1:0];
`ifdef LIF_ADAPT_THR_EN
      thr_sum = (W+1)'(thr_base) + (W+1)'(cur_off);
      thr     = thr_sum[W] ? VMAX : thr_sum[W-1:0];
      inc_sum = (W+1)'(cur_off) + (W+1)'(THR_INC);
`else
      thr = thr_base;
`endif
      refr  = (cur_r != '0);
      fire  = hit && !refr && (u >= thr);
      new_v = (hit && !refr && !fire) ? u : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            v[i] <= '0;
            r[i] <= '0;
`ifdef LIF_ADAPT_THR_EN
            thr_off[i] <= '0;
`endif
         end
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_spike <= 1'b0;
         out_state <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= in_idx;
            out_spike <= fire;
            out_state <= new_v;
            for (int i = 0; i < N; i++) begin
               if (in_idx == IDX_W'(i)) begin
                  v[i] <= new_v;
                  if (refr)
                     r[i] <= cur_r - R_W'(1);
                  else if (fire)
                     r[i] <= R_W'(REFRACT);
`ifdef LIF_ADAPT_THR_EN
                  if (fire)
                     thr_off[i] <= inc_sum[W] ? VMAX : inc_sum[W-1:0];
                  else if (!refr && cur_off != '0)
                     thr_off[i] <= cur_off - W'(1);
`endif
               end
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
